mem_bus_arbiter: RTL and testbench

- Shares one single-port data/instruction RAM between two requesters: the instruction-fetch stage (IF, read-only) and the memory-access stage (MEM, read/write with byte select).
- Sits between the pipeline and the RAM. It serializes accesses, holds the RAM interface stable until the RAM acknowledges, and raises a pipeline stall request while any request is outstanding.
- A watchdog aborts hung accesses so the pipeline never deadlocks.

---
 rtl/mem_bus_arbiter_if.sv | 51 +++++
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Handshake bundle between the pipeline (IF and MEM stages), the shared
//   single-port RAM and mem_bus_arbiter.
//   slave  : arbiter view (requests and RAM response in; grants, acks,
//            RAM drive, stall and error out).
//   master : pipeline/RAM view (the mirror image of slave).
interface mem_bus_arbiter_if;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;

  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;

  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_i;
  logic        ram_ack_i;

  logic        stallreq_o;
  logic        bus_err_o;

  modport slave (
    input  if_ce_i, if_addr_i,
    output if_data_o, if_ack_o,
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
    output mem_data_o, mem_ack_o,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o,
    input  ram_data_i, ram_ack_i,
    output stallreq_o, bus_err_o
  );

  modport master (
    output if_ce_i, if_addr_i,
    input  if_data_o, if_ack_o,
    output mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
    input  mem_data_o, mem_ack_o,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o,
    output ram_data_i, ram_ack_i,
    input  stallreq_o, bus_err_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port RAM between the instruction-fetch stage (read
//   only) and the memory-access stage (read/write with byte lanes). MEM has
//   fixed priority. RAM drive is registered and held until ram_ack_i; a
//   watchdog aborts an access after TIMEOUT cycles without an ack.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous reset, active low
//     bus  : mem_bus_arbiter_if.slave (requests, acks, RAM side, stall, error)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no access in flight; grant decision (MEM before IF)
//   IF_ACC  | RAM driven for an instruction fetch, waiting for ram_ack_i
//   MEM_ACC | RAM driven for a MEM read/write, waiting for ram_ack_i
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              ram_ce_q;
  logic              ram_we_q;
  logic [31:0]       ram_addr_q;
  logic [31:0]       ram_data_q;
  logic [3:0]        ram_sel_q;
  logic              if_ack_q;
  logic              mem_ack_q;
  logic              bus_err_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_data_q;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ram_ce_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_sel_q  <= '0;
      if_ack_q   <= 1'b0;
      mem_ack_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // A requester whose ack is high this cycle still holds ce_i; mask it
          // so the completed access is not granted a second time.
          if (bus.mem_ce_i && !mem_ack_q) begin
            ram_ce_q   <= 1'b1;
            ram_we_q   <= bus.mem_we_i;
            ram_addr_q <= bus.mem_addr_i;
            ram_data_q <= bus.mem_data_i;
            ram_sel_q  <= bus.mem_sel_i;
            state_q    <= MEM_ACC;
          end else if (bus.if_ce_i && !if_ack_q) begin
            ram_ce_q   <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= bus.if_addr_i;
            ram_data_q <= '0;
            ram_sel_q  <= 4'b1111;
            state_q    <= IF_ACC;
          end
        end
        IF_ACC, MEM_ACC: begin
          // An ack on the final watchdog cycle is checked first, so it wins.
          if (bus.ram_ack_i) begin
            if (state_q == IF_ACC) begin
              if_ack_q  <= 1'b1;
              if_data_q <= bus.ram_data_i;
            end else begin
              mem_ack_q  <= 1'b1;
              mem_data_q <= ram_we_q ? 32'h0 : bus.ram_data_i;
            end
            ram_ce_q <= 1'b0;
            ram_we_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            if (state_q == IF_ACC) begin
              if_ack_q  <= 1'b1;
              if_data_q <= '0;
            end else begin
              mem_ack_q  <= 1'b1;
              mem_data_q <= '0;
            end
            bus_err_q <= 1'b1;
            ram_ce_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q  <= IDLE;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign bus.ram_ce_o   = ram_ce_q;
  assign bus.ram_we_o   = ram_we_q;
  assign bus.ram_addr_o = ram_addr_q;
  assign bus.ram_data_o = ram_data_q;
  assign bus.ram_sel_o  = ram_sel_q;
  assign bus.if_ack_o   = if_ack_q;
  assign bus.if_data_o  = if_data_q;
  assign bus.mem_ack_o  = mem_ack_q;
  assign bus.mem_data_o = mem_data_q;
  assign bus.bus_err_o  = bus_err_q;

  // Stall while a request is held but its completion has not yet been seen.
  assign bus.stallreq_o = (bus.if_ce_i & ~if_ack_q) | (bus.mem_ce_i & ~mem_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.if_ce_i    = 1'b0;
    bus.if_addr_i  = '0;
    bus.mem_ce_i   = 1'b0;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = '0;
    bus.mem_data_i = '0;
    bus.mem_sel_i  = '0;
    bus.ram_data_i = '0;
    bus.ram_ack_i  = 1'b0;

    // Reset values
    #1;
    chk("rst_ram_ce",   {31'b0, bus.ram_ce_o}, 32'd0);
    chk("rst_ram_addr", bus.ram_addr_o, 32'd0);
    chk("rst_acks",     {29'b0, bus.if_ack_o, bus.mem_ack_o, bus.bus_err_o}, 32'd0);
    chk("rst_data",     bus.if_data_o | bus.mem_data_o, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // IF only, 1-cycle RAM ack
    bus.if_ce_i   = 1'b1;
    bus.if_addr_i = 32'h0000_0100;
    #1;
    chk("if_stall_pending", {31'b0, bus.stallreq_o}, 32'd1);
    step();
    chk("if_ram_ce",   {31'b0, bus.ram_ce_o}, 32'd1);
    chk("if_ram_addr", bus.ram_addr_o, 32'h0000_0100);
    chk("if_ram_sel",  {28'b0, bus.ram_sel_o}, 32'hF);
    chk("if_ram_we",   {31'b0, bus.ram_we_o}, 32'd0);
    bus.ram_ack_i  = 1'b1;
    bus.ram_data_i = 32'hCAFE_F00D;
    step();
    chk("if_ack",      {31'b0, bus.if_ack_o}, 32'd1);
    chk("if_data",     bus.if_data_o, 32'hCAFE_F00D);
    chk("if_ack_ce",   {31'b0, bus.ram_ce_o}, 32'd0);
    chk("if_ack_stall",{31'b0, bus.stallreq_o}, 32'd0);
    bus.if_ce_i   = 1'b0;
    bus.ram_ack_i = 1'b0;
    step();
    chk("if_ack_once", {31'b0, bus.if_ack_o}, 32'd0);
    chk("if_no_regrant", {31'b0, bus.ram_ce_o}, 32'd0);
    chk("if_stall_after", {31'b0, bus.stallreq_o}, 32'd0);
    chk("if_data_held", bus.if_data_o, 32'hCAFE_F00D);

    // MEM write, RAM ack on the third access cycle
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = 1'b1;
    bus.mem_addr_i = 32'h0000_0204;
    bus.mem_data_i = 32'hDEAD_BEEF;
    bus.mem_sel_i  = 4'b0011;
    step();
    bus.mem_data_i = 32'h0;
    bus.mem_addr_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_ram_ce",   {31'b0, bus.ram_ce_o}, 32'd1);
      chk("wr_ram_we",   {31'b0, bus.ram_we_o}, 32'd1);
      chk("wr_ram_addr", bus.ram_addr_o, 32'h0000_0204);
      chk("wr_ram_data", bus.ram_data_o, 32'hDEAD_BEEF);
      chk("wr_ram_sel",  {28'b0, bus.ram_sel_o}, 32'h3);
      chk("wr_stall",    {31'b0, bus.stallreq_o}, 32'd1);
      chk("wr_no_ack",   {31'b0, bus.mem_ack_o}, 32'd0);
      if (i == 2) begin
        bus.ram_ack_i  = 1'b1;
        bus.ram_data_i = 32'h1234_5678;
      end
      step();
    end
    chk("wr_ack",      {31'b0, bus.mem_ack_o}, 32'd1);
    chk("wr_data_zero", bus.mem_data_o, 32'd0);
    chk("wr_stall_ack", {31'b0, bus.stallreq_o}, 32'd0);
    chk("wr_ce_drop",  {30'b0, bus.ram_ce_o, bus.ram_we_o}, 32'd0);
    chk("wr_no_err",   {31'b0, bus.bus_err_o}, 32'd0);
    bus.mem_ce_i  = 1'b0;
    bus.mem_we_i  = 1'b0;
    bus.ram_ack_i = 1'b0;
    step();
    chk("wr_ack_once", {31'b0, bus.mem_ack_o}, 32'd0);

    // IF and MEM together: MEM first
    bus.if_ce_i    = 1'b1;
    bus.if_addr_i  = 32'h0000_0300;
    bus.mem_ce_i   = 1'b1;
    bus.mem_addr_i = 32'h0000_0400;
    bus.mem_sel_i  = 4'b1111;
    step();
    chk("both_mem_first", bus.ram_addr_o, 32'h0000_0400);
    chk("both_mem_we",    {31'b0, bus.ram_we_o}, 32'd0);
    bus.ram_ack_i  = 1'b1;
    bus.ram_data_i = 32'h1111_2222;
    step();
    chk("both_mem_ack",  {30'b0, bus.mem_ack_o, bus.if_ack_o}, 32'd2);
    chk("both_mem_data", bus.mem_data_o, 32'h1111_2222);
    chk("both_ce_gap",   {31'b0, bus.ram_ce_o}, 32'd0);
    bus.mem_ce_i  = 1'b0;
    bus.ram_ack_i = 1'b0;
    #1;
    chk("both_if_stall", {31'b0, bus.stallreq_o}, 32'd1);
    step();
    chk("both_if_grant", {31'b0, bus.ram_ce_o}, 32'd1);
    chk("both_if_addr",  bus.ram_addr_o, 32'h0000_0300);
    chk("both_acks_low", {30'b0, bus.mem_ack_o, bus.if_ack_o}, 32'd0);
    bus.ram_ack_i  = 1'b1;
    bus.ram_data_i = 32'h3333_4444;
    step();
    chk("both_if_ack",  {30'b0, bus.mem_ack_o, bus.if_ack_o}, 32'd1);
    chk("both_if_data", bus.if_data_o, 32'h3333_4444);
    chk("both_mem_data_held", bus.mem_data_o, 32'h1111_2222);
    bus.if_ce_i   = 1'b0;
    bus.ram_ack_i = 1'b0;
    step();
    chk("both_idle", {29'b0, bus.ram_ce_o, bus.mem_ack_o, bus.if_ack_o}, 32'd0);

    // Watchdog abort: 16 access cycles with no ack
    bus.mem_ce_i   = 1'b1;
    bus.mem_addr_i = 32'h0000_0500;
    step();
    for (int k = 0; k < 15; k++) begin
      chk("to_waiting", {29'b0, bus.ram_ce_o, bus.mem_ack_o, bus.bus_err_o}, 32'h4);
      step();
    end
    chk("to_last_cycle", {29'b0, bus.ram_ce_o, bus.mem_ack_o, bus.bus_err_o}, 32'h4);
    step();
    chk("to_abort",      {29'b0, bus.ram_ce_o, bus.mem_ack_o, bus.bus_err_o}, 32'h3);
    chk("to_data_zero",  bus.mem_data_o, 32'd0);
    bus.mem_ce_i = 1'b0;
    step();
    chk("to_pulse_once", {30'b0, bus.mem_ack_o, bus.bus_err_o}, 32'd0);
    bus.if_ce_i   = 1'b1;
    bus.if_addr_i = 32'h0000_0600;
    step();
    chk("to_next_grant", bus.ram_addr_o, 32'h0000_0600);
    bus.ram_ack_i  = 1'b1;
    bus.ram_data_i = 32'h5555_AAAA;
    step();
    chk("to_next_ack",  {31'b0, bus.if_ack_o}, 32'd1);
    chk("to_next_data", bus.if_data_o, 32'h5555_AAAA);
    bus.if_ce_i   = 1'b0;
    bus.ram_ack_i = 1'b0;
    step();

    // Ack on the final watchdog cycle wins
    bus.mem_ce_i   = 1'b1;
    bus.mem_addr_i = 32'h0000_0700;
    step();
    for (int k = 0; k < 15; k++) step();
    chk("edge_still_busy", {31'b0, bus.ram_ce_o}, 32'd1);
    bus.ram_ack_i  = 1'b1;
    bus.ram_data_i = 32'h7777_8888;
    step();
    chk("edge_ack",    {30'b0, bus.mem_ack_o, bus.bus_err_o}, 32'h2);
    chk("edge_data",   bus.mem_data_o, 32'h7777_8888);
    bus.mem_ce_i  = 1'b0;
    bus.ram_ack_i = 1'b0;
    step();

    // Asynchronous reset two cycles into a MEM access
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = 1'b1;
    bus.mem_addr_i = 32'h0000_0800;
    bus.mem_data_i = 32'h0000_AAAA;
    bus.mem_sel_i  = 4'b1111;
    step();
    step();
    chk("ar_busy", {31'b0, bus.ram_ce_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_ram_ctl",  {30'b0, bus.ram_ce_o, bus.ram_we_o}, 32'd0);
    chk("ar_ram_addr", bus.ram_addr_o | bus.ram_data_o, 32'd0);
    chk("ar_acks",     {29'b0, bus.if_ack_o, bus.mem_ack_o, bus.bus_err_o}, 32'd0);
    chk("ar_data",     bus.if_data_o | bus.mem_data_o, 32'd0);
    bus.mem_ce_i = 1'b0;
    bus.mem_we_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("ar_idle", {31'b0, bus.ram_ce_o}, 32'd0);
    bus.if_ce_i   = 1'b1;
    bus.if_addr_i = 32'h0000_0900;
    step();
    chk("ar_if_grant", bus.ram_addr_o, 32'h0000_0900);
    chk("ar_if_ce",    {31'b0, bus.ram_ce_o}, 32'd1);
    bus.ram_ack_i  = 1'b1;
    bus.ram_data_i = 32'h9999_0001;
    step();
    chk("ar_if_ack",  {31'b0, bus.if_ack_o}, 32'd1);
    chk("ar_if_data", bus.if_data_o, 32'h9999_0001);
    bus.if_ce_i   = 1'b0;
    bus.ram_ack_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
